// File: rtl/scazator_serial_if.sv
// scazator_serial_if -- bundle of the serial subtractor's request and result
// signals.
//   N         : operand width in bits
//   start     : request a subtraction (sampled on rising clk)
//   A, B, Bin : minuend, subtrahend, borrow-in (captured with start)
//   busy      : operation in progress (RUN or DONE)
//   S_ser     : serial difference bit, LSB first; 0 when S_vld is low
//   S_vld     : S_ser is valid this cycle
//   D         : registered parallel difference
//   Bout      : registered borrow-out
//   V         : registered two's-complement overflow flag
//   done      : one-cycle pulse, D/Bout/V valid
//   fsm_state : current FSM state (0 IDLE, 1 RUN, 2 DONE), for observation
// Handshake: start is only accepted while busy is low. It is a level sampled on
// a rising edge; while busy is high it is ignored and not queued. done pulses
// once per accepted start, unless the operation was aborted by reset.
interface scazator_serial_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Bin;
  logic         busy;
  logic         S_ser;
  logic         S_vld;
  logic [N-1:0] D;
  logic         Bout;
  logic         V;
  logic         done;
  logic [1:0]   fsm_state;

  modport master (
    output start, A, B, Bin,
    input  busy, S_ser, S_vld, D, Bout, V, done, fsm_state
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, S_ser, S_vld, D, Bout, V, done, fsm_state
  );
endinterface

// File: rtl/scazator_serial.sv
// scazator_serial -- bit-serial subtractor computing {Bout, D} = A - B - Bin.
// One difference bit is produced per cycle, LSB first, over N RUN cycles. The
// registered results are then presented with a one-cycle done pulse.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : scazator_serial_if slave modport (request, serial and parallel results)
module scazator_serial #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  scazator_serial_if.slave   bus
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  ra, ra_nxt;
  logic [N-1:0]  rb, rb_nxt;
  logic          br, br_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          msb_a, msb_a_nxt;
  logic          msb_b, msb_b_nxt;
  logic [N-1:0]  d_q, d_nxt;
  logic          bout_q, bout_nxt;
  logic          v_q, v_nxt;

  logic          diff_bit;
  logic          borrow;

  // Full subtractor on the current LSBs.
  assign diff_bit = ra[0] ^ rb[0] ^ br;
  assign borrow   = (~ra[0] & rb[0]) | (~ra[0] & br) | (rb[0] & br);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      msb_a  <= 1'b0;
      msb_b  <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      ra     <= ra_nxt;
      rb     <= rb_nxt;
      br     <= br_nxt;
      cnt    <= cnt_nxt;
      msb_a  <= msb_a_nxt;
      msb_b  <= msb_b_nxt;
      d_q    <= d_nxt;
      bout_q <= bout_nxt;
      v_q    <= v_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ra_nxt    = ra;
    rb_nxt    = rb;
    br_nxt    = br;
    cnt_nxt   = cnt;
    msb_a_nxt = msb_a;
    msb_b_nxt = msb_b;
    d_nxt     = d_q;
    bout_nxt  = bout_q;
    v_nxt     = v_q;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          ra_nxt    = bus.A;
          rb_nxt    = bus.B;
          br_nxt    = bus.Bin;
          cnt_nxt   = '0;
          msb_a_nxt = bus.A[N-1];
          msb_b_nxt = bus.B[N-1];
        end
      end
      RUN: begin
        // ra doubles as the result register: the minuend bit consumed each
        // cycle frees its MSB slot for the new difference bit. After N shifts
        // ra holds the complete difference.
        ra_nxt  = {diff_bit, ra[N-1:1]};
        rb_nxt  = {1'b0, rb[N-1:1]};
        br_nxt  = borrow;
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          state_nxt = DONE;
          // The last difference bit is the MSB of D.
          d_nxt     = {diff_bit, ra[N-1:1]};
          bout_nxt  = borrow;
          v_nxt     = (msb_a ^ msb_b) & (msb_a ^ diff_bit);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.S_vld     = (state == RUN);
  assign bus.S_ser     = (state == RUN) & diff_bit;
  assign bus.done      = (state == DONE);
  assign bus.D         = d_q;
  assign bus.Bout      = bout_q;
  assign bus.V         = v_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_scazator_serial.sv
// tb_scazator_serial -- directed bench for scazator_serial with N=8.
module tb_scazator_serial;

  localparam int N = 8;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] prev_d;
  logic         prev_bout;
  logic         prev_v;

  scazator_serial_if #(.N(N)) bus ();

  scazator_serial #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation from IDLE and follows it to the end of the done cycle.
  // It checks the serial stream against the expected difference bits. It also
  // checks that the previous results hold during RUN.
  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic bi, input logic [N-1:0] exp_d, input logic exp_b,
                        input logic exp_v);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bi;
    tick();
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    bus.Bin   = ~bi;
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s s_vld[%0d]", name, i), {31'd0, bus.S_vld}, 32'd1);
      check($sformatf("%s s_ser[%0d]", name, i), {31'd0, bus.S_ser}, {31'd0, exp_d[i]});
      check($sformatf("%s busy[%0d]", name, i), {31'd0, bus.busy}, 32'd1);
      check($sformatf("%s no_done[%0d]", name, i), {31'd0, bus.done}, 32'd0);
      check($sformatf("%s d_hold[%0d]", name, i), {24'd0, bus.D}, {24'd0, prev_d});
      check($sformatf("%s v_hold[%0d]", name, i), {30'd0, bus.Bout, bus.V},
            {30'd0, prev_bout, prev_v});
      tick();
    end
    check({name, " done"}, {31'd0, bus.done}, 32'd1);
    check({name, " busy_done"}, {31'd0, bus.busy}, 32'd1);
    check({name, " s_vld_done"}, {30'd0, bus.S_vld, bus.S_ser}, 32'd0);
    check({name, " D"}, {24'd0, bus.D}, {24'd0, exp_d});
    check({name, " Bout"}, {31'd0, bus.Bout}, {31'd0, exp_b});
    check({name, " V"}, {31'd0, bus.V}, {31'd0, exp_v});
    tick();
    check({name, " done_fall"}, {31'd0, bus.done}, 32'd0);
    check({name, " idle"}, {30'd0, bus.busy, bus.fsm_state == 2'd0}, 32'd1);
    check({name, " D_keep"}, {24'd0, bus.D}, {24'd0, exp_d});
    prev_d    = exp_d;
    prev_bout = exp_b;
    prev_v    = exp_v;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    prev_d    = '0;
    prev_bout = 1'b0;
    prev_v    = 1'b0;

    // reset state
    #3;
    check("rst state", {30'd0, bus.fsm_state}, 32'd0);
    check("rst flags", {26'd0, bus.busy, bus.S_ser, bus.S_vld, bus.done, bus.Bout, bus.V}, 32'd0);
    check("rst D", {24'd0, bus.D}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First start is accepted at the first edge after release.
    run_op("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op("sub_03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("sub_00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("sub_50_20_b", 8'h50, 8'h20, 1'b1, 8'h2F, 1'b0, 1'b0);

    // start re-pulsed during RUN is ignored
    bus.start = 1'b1;
    bus.A     = 8'h10;
    bus.B     = 8'h01;
    bus.Bin   = 1'b0;
    tick();                               // cycle k+1
    bus.start = 1'b0;
    check("repulse busy k+1", {31'd0, bus.busy}, 32'd1);
    tick();                               // cycle k+2
    check("repulse busy k+2", {31'd0, bus.busy}, 32'd1);
    tick();                               // cycle k+3, sampled at edge k+3
    check("repulse busy k+3", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b1;
    bus.A     = 8'hAA;
    bus.B     = 8'h55;
    bus.Bin   = 1'b1;
    tick();                               // cycle k+4
    bus.start = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      check($sformatf("repulse busy k+%0d", c), {31'd0, bus.busy}, 32'd1);
      check($sformatf("repulse no_done k+%0d", c), {31'd0, bus.done}, 32'd0);
      tick();
    end
    check("repulse done k+9", {31'd0, bus.done}, 32'd1);
    check("repulse busy k+9", {31'd0, bus.busy}, 32'd1);
    check("repulse D", {24'd0, bus.D}, 32'h0F);
    check("repulse Bout_V", {30'd0, bus.Bout, bus.V}, 32'd0);
    tick();
    check("repulse idle", {30'd0, bus.busy, bus.done}, 32'd0);
    prev_d    = 8'h0F;
    prev_bout = 1'b0;
    prev_v    = 1'b0;

    run_op("sub_7F_FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // reset asserted mid-RUN
    bus.start = 1'b1;
    bus.A     = 8'h33;
    bus.B     = 8'h11;
    bus.Bin   = 1'b0;
    tick();                               // cycle k+1
    bus.start = 1'b0;
    repeat (3) tick();                    // cycle k+4
    check("midrst running", {30'd0, bus.fsm_state}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst state", {30'd0, bus.fsm_state}, 32'd0);
    check("midrst flags", {26'd0, bus.busy, bus.S_ser, bus.S_vld, bus.done, bus.Bout, bus.V},
          32'd0);
    check("midrst D", {24'd0, bus.D}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < N + 3; c++) begin
      tick();
      check($sformatf("midrst no_done[%0d]", c), {30'd0, bus.done, bus.busy}, 32'd0);
    end
    prev_d    = '0;
    prev_bout = 1'b0;
    prev_v    = 1'b0;

    run_op("after_rst_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
